// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetch FIFO between a multi-cycle imem and the core
// Optional zero-latency bypass of an empty queue: `define PFQ_BYPASS_EN
module instr_prefetch_queue #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic                   CLK,
  input  logic                   resetl,
  input  logic [ADDR_W-1:0]      startpc,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_ack,
  input  logic [INSTR_W-1:0]     mem_data,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [INSTR_W-1:0]     inst_data,
  output logic [ADDR_W-1:0]      inst_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0]  pc_mem_q   [DEPTH];
  logic [INSTR_W-1:0] data_mem_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               mem_req_q, mem_req_d, discard_q, discard_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d, fpc_q, fpc_d, base_pc;
  logic               ack_v, fifo_nonempty, bypass, push, pop;
  logic [CW:0]        occ;

  // An ack without an outstanding request is a protocol error and is dropped here.
  assign ack_v         = mem_ack & mem_req_q;
  assign fifo_nonempty = (count_q != '0);

`ifdef PFQ_BYPASS_EN
  assign bypass     = ~fifo_nonempty & ack_v & ~discard_q & ~redirect;
  assign inst_valid = fifo_nonempty | bypass;
  assign inst_data  = fifo_nonempty ? data_mem_q[rd_ptr_q] : mem_data;
  assign inst_pc    = fifo_nonempty ? pc_mem_q[rd_ptr_q] : mem_addr_q;
`else
  assign bypass     = 1'b0;
  assign inst_valid = fifo_nonempty;
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];
`endif

  // A bypassed entry taken by the core this cycle never touches the FIFO.
  assign push = ack_v & ~discard_q & ~redirect & ~(bypass & inst_ready);
  assign pop  = inst_valid & inst_ready & ~redirect & ~bypass;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    discard_d  = discard_q;
    base_pc    = redirect ? redirect_pc : fpc_q;
    fpc_d      = base_pc;
    occ        = {1'b0, count_q} + (CW+1)'(push) - (CW+1)'(pop);
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      occ      = '0;
    end
    count_d = occ[CW-1:0];

    if ((!mem_req_q || ack_v) && (occ < (CW+1)'(DEPTH))) begin
      mem_req_d  = 1'b1;
      mem_addr_d = base_pc;
      fpc_d      = base_pc + ADDR_W'(4);
    end else if (ack_v) begin
      mem_req_d = 1'b0;
    end

    // The in-flight request keeps its old address; only its response is thrown away.
    if (ack_v)                      discard_d = 1'b0;
    else if (redirect && mem_req_q) discard_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (resetl) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      fpc_q      <= startpc;
      discard_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fpc_q      <= fpc_d;
      discard_q  <= discard_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!resetl && push) begin
      pc_mem_q[wr_ptr_q]   <= mem_addr_q;
      data_mem_q[wr_ptr_q] <= mem_data;
    end
  end

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign count    = count_q;
endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - directed vector bench for instr_prefetch_queue (default build)
module tb_instr_prefetch_queue;
  logic        CLK;
  logic        resetl;
  logic [63:0] startpc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  instr_prefetch_queue #(.DEPTH(4), .ADDR_W(64), .INSTR_W(32)) dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data),
    .inst_pc(inst_pc), .count(count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic        rst, ack, rdy, redir;
    logic [63:0] rpc;
    logic        req;
    logic [63:0] addr;
    logic        valid;
    logic [63:0] pc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic ack, logic rdy, logic redir, logic [63:0] rpc,
                              logic req, logic [63:0] addr, logic valid, logic [63:0] pc,
                              logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.ack = ack; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid; v.pc = pc; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_data();
    mem_data = mem_addr[31:0] ^ 32'hA5A5A5A5;
  endtask

  initial begin
    logic [63:0] wrap_addr [3];
    logic [63:0] wrap_pc   [3];
    logic [31:0] exp_data;

    resetl = 1'b1; startpc = 64'h1000; redirect = 1'b0; redirect_pc = '0;
    mem_ack = 1'b0; mem_data = '0; inst_ready = 1'b0;

    //          rst ack rdy red rpc        req addr      val pc        cnt
    vq.push_back(mk(1, 0, 0, 0, 64'h0,    0, 64'h0,    0, 64'h0,    3'd0));
    vq.push_back(mk(1, 0, 0, 0, 64'h0,    0, 64'h0,    0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h1004, 1, 64'h1000, 3'd1));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h1008, 1, 64'h1004, 3'd1));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h100C, 1, 64'h1008, 3'd1));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    1, 64'h1010, 1, 64'h1008, 3'd2));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    1, 64'h1014, 1, 64'h1008, 3'd3));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    0, 64'h1014, 1, 64'h1008, 3'd4));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    0, 64'h1014, 1, 64'h1008, 3'd4));
    vq.push_back(mk(0, 0, 1, 0, 64'h0,    1, 64'h1018, 1, 64'h100C, 3'd3));
    vq.push_back(mk(0, 0, 1, 0, 64'h0,    1, 64'h1018, 1, 64'h1010, 3'd2));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h101C, 1, 64'h1014, 3'd2));
    vq.push_back(mk(0, 0, 0, 1, 64'h8000, 1, 64'h101C, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    1, 64'h101C, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    1, 64'h101C, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    1, 64'h8000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h8004, 1, 64'h8000, 3'd1));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    1, 64'h8004, 1, 64'h8000, 3'd1));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    1, 64'h8008, 1, 64'h8000, 3'd2));
    vq.push_back(mk(0, 1, 1, 1, 64'h3000, 1, 64'h3000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 1, 0, 64'h0,    1, 64'h3000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 1, 1, 64'h4000, 1, 64'h3000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 1, 1, 64'h5000, 1, 64'h3000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 1, 1, 0, 64'h0,    1, 64'h5000, 0, 64'h0,    3'd0));
    vq.push_back(mk(0, 1, 0, 0, 64'h0,    1, 64'h5004, 1, 64'h5000, 3'd1));
    vq.push_back(mk(1, 1, 1, 1, 64'h9000, 0, 64'h0,    0, 64'h0,    3'd0));
    vq.push_back(mk(0, 0, 0, 0, 64'h0,    1, 64'h1000, 0, 64'h0,    3'd0));

    for (int i = 0; i < vq.size(); i++) begin
      resetl      = vq[i].rst;
      mem_ack     = vq[i].ack;
      inst_ready  = vq[i].rdy;
      redirect    = vq[i].redir;
      redirect_pc = vq[i].rpc;
      drive_data();
      if (vq[i].ack && !vq[i].rst) chk($sformatf("v%0d.ack_needs_req", i), 64'(mem_req), 64'd1);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d.mem_req", i),    64'(mem_req),    64'(vq[i].req));
      chk($sformatf("v%0d.mem_addr", i),   mem_addr,        vq[i].addr);
      chk($sformatf("v%0d.inst_valid", i), 64'(inst_valid), 64'(vq[i].valid));
      chk($sformatf("v%0d.count", i),      64'(count),      64'(vq[i].cnt));
      if (vq[i].valid) begin
        exp_data = vq[i].pc[31:0] ^ 32'hA5A5A5A5;
        chk($sformatf("v%0d.inst_pc", i),   inst_pc,         vq[i].pc);
        chk($sformatf("v%0d.inst_data", i), 64'(inst_data),  64'(exp_data));
      end
    end

    // Fetch PC wraps past the top of the address space.
    wrap_addr[0] = 64'hFFFF_FFFF_FFFF_FFFC; wrap_addr[1] = 64'h0; wrap_addr[2] = 64'h4;
    wrap_pc[0]   = 64'hFFFF_FFFF_FFFF_FFF8; wrap_pc[1]   = 64'hFFFF_FFFF_FFFF_FFFC; wrap_pc[2] = 64'h0;
    resetl = 1'b1; startpc = 64'hFFFF_FFFF_FFFF_FFF8; mem_ack = 1'b0; redirect = 1'b0; inst_ready = 1'b1;
    @(posedge CLK); #1;
    chk("wrap.reset_req", 64'(mem_req), 64'd0);
    resetl = 1'b0;
    @(posedge CLK); #1;
    chk("wrap.first_addr", mem_addr, 64'hFFFF_FFFF_FFFF_FFF8);
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      drive_data();
      @(posedge CLK); #1;
      chk($sformatf("wrap%0d.mem_addr", k), mem_addr, wrap_addr[k]);
      chk($sformatf("wrap%0d.inst_pc", k),  inst_pc,  wrap_pc[k]);
      chk($sformatf("wrap%0d.valid", k),    64'(inst_valid), 64'd1);
    end
    mem_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
